bforge_apb_req_arbiter: RTL and testbench

- Multi-requester APB master front end. Arbitrates NUM_REQ simple request channels with round-robin priority and sequences the winning request through the APB SETUP and ACCESS phases on a single shared APB bus.
- Returns the response (rdata, slave error) to the granted requester.
- Sits between VIP sequencer/driver-side request sources and the bforge APB interface signals.

---
 rtl/bforge_apb_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_bforge_apb_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bforge_apb_req_arbiter.sv
// bforge_apb_req_arbiter
//   Round-robin arbiter for NUM_REQ simple request channels. It runs the
//   winning request through the APB SETUP and ACCESS phases on one shared
//   bus and returns the response to the requester that owns the transfer.
//
// Optional feature macro: BFORGE_APB_TIMEOUT_EN
//   When defined, an ACCESS phase that stays in wait states for
//   TIMEOUT_CYCLES cycles is aborted. The owner then gets an error response
//   and timeout pulses for one cycle. When undefined, ACCESS waits forever
//   and timeout is tied low.
//
// Ports
//   pclk, presetn            clock, async active-low reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_addr/_write/_wdata/_strb   packed per-requester payload, slice i = requester i
//   rsp_valid                one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err       shared response, qualified by rsp_valid
//   timeout                  one-cycle ACCESS timeout pulse
//   psel..pstrb, prdata, pready, pslverr   APB master side
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate; accept the granted request into the APB registers
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout abort)
module bforge_apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          timeout,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_WIDTH-1:0]         pstrb,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("bforge_apb_req_arbiter: NUM_REQ must be in 2..8");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
    $error("bforge_apb_req_arbiter: DATA_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bforge_apb_req_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t                  state;
  logic [PTR_W-1:0]        last_grant;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic                    grant_found;
  logic [NUM_REQ-1:0]      owner_oh;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [STRB_WIDTH-1:0]   sel_strb;
  logic                    sel_write;

  // Search starts just past the last winner and wraps, so the most recent
  // winner always has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == PTR_W'(i));
  end

`ifdef BFORGE_APB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter of remaining wait states; abort when a wait cycle
  // arrives with the counter already at zero.
  logic [TMR_W-1:0] tmr;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= ST_IDLE;
      last_grant <= PTR_W'(NUM_REQ - 1);
      owner      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef BFORGE_APB_TIMEOUT_EN
      tmr        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
`ifdef BFORGE_APB_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            paddr      <= sel_addr;
            pwrite     <= sel_write;
            // Reads never drive data or strobes onto the bus.
            pwdata     <= sel_write ? sel_wdata : '0;
            pstrb      <= sel_write ? sel_strb  : '0;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            psel       <= 1'b1;
            penable    <= 1'b0;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
`ifdef BFORGE_APB_TIMEOUT_EN
          tmr     <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= ST_IDLE;
            rsp_valid <= owner_oh;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
          end
`ifdef BFORGE_APB_TIMEOUT_EN
          else if (tmr == '0) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= ST_IDLE;
            rsp_valid <= owner_oh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bforge_apb_req_arbiter.sv
module tb_bforge_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            timeout;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  bforge_apb_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timeout(timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs for one cycle and the outputs expected in that same cycle.
  typedef struct {
    logic [3:0]  valid;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  ready;
    logic        psel;
    logic        pen;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic [3:0]  rsp;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int  ngrant;
  int  nwait;
  bit  done;

  initial begin
    // Requester payloads: 0/1 write, 2/3 read (their wdata/strb must be masked).
    req_addr  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010, 32'h0000_0100};
    req_write = 4'b0011;
    req_wdata = {32'h3333_3333, 32'h5555_5555, 32'hDEAD_BEEF, 32'hA0A0_A0A0};
    req_strb  = {4'hF, 4'hC, 4'hF, 4'h3};
    req_valid = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    presetn   = 1'b1;

    #1 presetn = 1'b0;
    #2;
    chk("rst psel", psel, 0);
    chk("rst penable", penable, 0);
    chk("rst pwrite", pwrite, 0);
    chk("rst paddr", paddr, 0);
    chk("rst pwdata", pwdata, 0);
    chk("rst pstrb", pstrb, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst timeout", timeout, 0);
    @(posedge pclk); #1 presetn = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      chk($sformatf("idle%0d psel", c), psel, 0);
      @(posedge pclk); #1;
    end

    //          valid pr  prdata        err  ready psel pen paddr   pwdata        strb wr  rsp  rdata         err
    tbl[0]  = '{4'h0, 0, 32'h0,         0,   4'h0, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[1]  = '{4'h2, 1, 32'hFFFF0000,  0,   4'h2, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[2]  = '{4'h0, 1, 32'hFFFF0000,  0,   4'h0, 1,   0,  32'h10, 32'hDEADBEEF, 4'hF, 1, 4'h0, 32'h0,        0};
    tbl[3]  = '{4'h0, 1, 32'hFFFF0000,  0,   4'h0, 1,   1,  32'h10, 32'hDEADBEEF, 4'hF, 1, 4'h0, 32'h0,        0};
    tbl[4]  = '{4'h0, 0, 32'h0,         0,   4'h0, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h2, 32'h0,        0};
    tbl[5]  = '{4'h4, 0, 32'h0,         0,   4'h4, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[6]  = '{4'h0, 0, 32'h0,         0,   4'h0, 1,   0,  32'h20, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[7]  = '{4'h0, 0, 32'h0,         0,   4'h0, 1,   1,  32'h20, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[8]  = '{4'h0, 0, 32'h0,         0,   4'h0, 1,   1,  32'h20, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[9]  = '{4'h0, 0, 32'h0,         0,   4'h0, 1,   1,  32'h20, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[10] = '{4'h0, 1, 32'h12345678,  1,   4'h0, 1,   1,  32'h20, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[11] = '{4'h8, 0, 32'h0,         0,   4'h8, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h4, 32'h12345678, 1};
    tbl[12] = '{4'h0, 0, 32'h0,         0,   4'h0, 1,   0,  32'h30, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[13] = '{4'h1, 0, 32'h0,         0,   4'h0, 1,   1,  32'h30, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[14] = '{4'h1, 0, 32'h0,         0,   4'h0, 1,   1,  32'h30, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[15] = '{4'h0, 1, 32'hCAFEF00D,  0,   4'h0, 1,   1,  32'h30, 32'h0,        4'h0, 0, 4'h0, 32'h0,        0};
    tbl[16] = '{4'h0, 0, 32'h0,         0,   4'h0, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h8, 32'hCAFEF00D, 0};
    tbl[17] = '{4'h0, 0, 32'h0,         0,   4'h0, 0,   0,  32'h0,  32'h0,        4'h0, 0, 4'h0, 32'h0,        0};

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].valid;
      pready    = tbl[i].pready;
      prdata    = tbl[i].prdata;
      pslverr   = tbl[i].pslverr;
      @(negedge pclk);
      chk($sformatf("v%0d req_ready", i), req_ready, tbl[i].ready);
      chk($sformatf("v%0d psel", i), psel, tbl[i].psel);
      chk($sformatf("v%0d penable", i), penable, tbl[i].pen);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, tbl[i].rsp);
      chk($sformatf("v%0d timeout", i), timeout, 0);
      if (tbl[i].psel) begin
        chk($sformatf("v%0d paddr", i), paddr, tbl[i].paddr);
        chk($sformatf("v%0d pwdata", i), pwdata, tbl[i].pwdata);
        chk($sformatf("v%0d pstrb", i), pstrb, tbl[i].pstrb);
        chk($sformatf("v%0d pwrite", i), pwrite, tbl[i].pwrite);
      end
      if (tbl[i].rsp != 4'h0) begin
        chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, tbl[i].rdata);
        chk($sformatf("v%0d rsp_err", i), rsp_err, tbl[i].err);
      end
      @(posedge pclk); #1;
    end

    // All four requesters held: grants must rotate 0,1,2,3,0,1,2,3.
    req_valid = 4'hF;
    pready    = 1'b1;
    prdata    = 32'h0BAD_F00D;
    pslverr   = 1'b0;
    ngrant    = 0;
    for (int c = 0; c < 60 && ngrant < 8; c++) begin
      @(negedge pclk);
      if (req_ready != 4'h0) begin
        chk($sformatf("rr%0d onehot", ngrant), 32'($onehot(req_ready)), 1);
        chk($sformatf("rr%0d psel_low", ngrant), psel, 0);
        chk($sformatf("rr%0d grant", ngrant), req_ready, 32'h1 << (ngrant % 4));
        ngrant++;
      end
      @(posedge pclk); #1;
    end
    chk("rr grant count", ngrant, 8);
    req_valid = '0;
    repeat (4) begin @(posedge pclk); #1; end

    // Reset in the middle of ACCESS: bus drops at once, no response later.
    req_valid = 4'h2;
    pready    = 1'b0;
    @(posedge pclk); #1 req_valid = '0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("midrst in access", penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("midrst psel", psel, 0);
    chk("midrst penable", penable, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    pready  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      chk($sformatf("midrst%0d rsp_valid", c), rsp_valid, 0);
      chk($sformatf("midrst%0d psel", c), psel, 0);
      @(posedge pclk); #1;
    end

`ifdef BFORGE_APB_TIMEOUT_EN
    // pready stuck low: abort after TO wait cycles, then a normal transfer.
    req_valid = 4'h1;
    pready    = 1'b0;
    @(posedge pclk); #1 req_valid = '0;
    nwait = 0;
    done  = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge pclk);
      if (rsp_valid != 4'h0) begin
        done = 1'b1;
        chk("to rsp_valid", rsp_valid, 4'h1);
        chk("to timeout", timeout, 1);
        chk("to rsp_err", rsp_err, 1);
        chk("to rsp_rdata", rsp_rdata, 0);
        chk("to psel", psel, 0);
      end else if (penable) begin
        nwait++;
      end
      @(posedge pclk); #1;
    end
    chk("to completed", 32'(done), 1);
    chk("to wait cycles", nwait, TO);
    req_valid = 4'h4;
    pready    = 1'b1;
    prdata    = 32'h0000_00A5;
    pslverr   = 1'b0;
    @(posedge pclk); #1 req_valid = '0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("to next rsp_valid", rsp_valid, 4'h4);
    chk("to next timeout", timeout, 0);
    chk("to next rsp_err", rsp_err, 0);
    chk("to next rsp_rdata", rsp_rdata, 32'h0000_00A5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
